// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester front end for the single-port unified ram.
// Port 0 is the cpu side, port 1 the loader/debug side. One access is in
// flight at a time; every requester-facing and ram-facing signal is a flop.
module mem_arbiter #(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int FAIR = 1
) (
  input  logic          clk,
  input  logic          reset,
  // requester 0
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          done0,
  // requester 1
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          done1,
  // shared response / status
  output logic [DW-1:0] rdata,
  output logic          busy,
  // ram side
  output logic          mem_cs,
  output logic          mem_we,
  output logic          mem_oe,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Requester inputs gathered into index-able form so the winner can be muxed.
  logic [1:0]    req_vec;
  logic [1:0]    we_vec;
  logic [AW-1:0] addr_vec  [2];
  logic [DW-1:0] wdata_vec [2];

  // Registered state and outputs.
  state_t        state_reg;
  logic          last_reg;    // port granted most recently (tie-break memory)
  logic          owner_reg;   // port that owns the access in flight
  logic          wr_reg;      // in-flight access is a write
  logic [1:0]    gnt_reg;
  logic [1:0]    done_reg;
  logic [DW-1:0] rdata_reg;
  logic          busy_reg;
  logic          cs_reg;
  logic          we_reg;
  logic          oe_reg;
  logic [AW-1:0] addr_reg;
  logic [DW-1:0] wdata_reg;

  // Winner selection results.
  logic          win_valid;
  logic          win_port;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      // Route port gi's request bundle into the shared vectors.
      assign req_vec[gi]   = (gi == 0) ? req0   : req1;
      assign we_vec[gi]    = (gi == 0) ? we0    : we1;
      assign addr_vec[gi]  = (gi == 0) ? addr0  : addr1;
      assign wdata_vec[gi] = (gi == 0) ? wdata0 : wdata1;
    end
  endgenerate

  // Pick the winner among current requesters; a tie goes to the port that
  // was not granted last (round-robin) or always to port 0 (fixed priority).
  always_comb begin
    win_valid = |req_vec;
    win_port  = 1'b0;
    if (&req_vec) begin
      win_port = (FAIR != 0) ? ~last_reg : 1'b0;
    end else begin
      win_port = req_vec[1];
    end
    sel_we    = we_vec[win_port];
    sel_addr  = addr_vec[win_port];
    sel_wdata = wdata_vec[win_port];
  end

  // Arbitration FSM; all outputs are produced directly from these flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      last_reg  <= 1'b1;
      owner_reg <= 1'b0;
      wr_reg    <= 1'b0;
      gnt_reg   <= 2'b00;
      done_reg  <= 2'b00;
      rdata_reg <= '0;
      busy_reg  <= 1'b0;
      cs_reg    <= 1'b0;
      we_reg    <= 1'b0;
      oe_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      // Grant and done are single-cycle pulses.
      gnt_reg  <= 2'b00;
      done_reg <= 2'b00;
      case (state_reg)
        IDLE: begin
          if (win_valid) begin
            state_reg <= ACCESS;
            owner_reg <= win_port;
            last_reg  <= win_port;
            wr_reg    <= sel_we;
            gnt_reg   <= win_port ? 2'b10 : 2'b01;
            busy_reg  <= 1'b1;
            // Ram strobes are presented in the very first ACCESS cycle.
            cs_reg    <= 1'b1;
            we_reg    <= sel_we;
            oe_reg    <= ~sel_we;
            addr_reg  <= sel_addr;
            wdata_reg <= sel_wdata;
          end
        end
        ACCESS: begin
          we_reg <= 1'b0;
          if (wr_reg) begin
            // Write is committed by the ram on this edge; finish now.
            state_reg <= IDLE;
            cs_reg    <= 1'b0;
            oe_reg    <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= owner_reg ? 2'b10 : 2'b01;
          end else begin
            // Read: keep cs/oe up one more cycle while ram data arrives.
            state_reg <= RESP;
          end
        end
        RESP: begin
          state_reg <= IDLE;
          rdata_reg <= mem_rdata;
          cs_reg    <= 1'b0;
          oe_reg    <= 1'b0;
          busy_reg  <= 1'b0;
          done_reg  <= owner_reg ? 2'b10 : 2'b01;
        end
        default: begin
          state_reg <= IDLE;
          cs_reg    <= 1'b0;
          we_reg    <= 1'b0;
          oe_reg    <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt0      = gnt_reg[0];
  assign gnt1      = gnt_reg[1];
  assign done0     = done_reg[0];
  assign done1     = done_reg[1];
  assign rdata     = rdata_reg;
  assign busy      = busy_reg;
  assign mem_cs    = cs_reg;
  assign mem_we    = we_reg;
  assign mem_oe    = oe_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;

endmodule
